// File: rtl/set_bit_serializer_pkg.sv
// Shared types and helpers for the set-bit serializer.
// Optional popcount output is enabled by SET_BIT_SERIALIZER_COUNT_EN (see top).
package set_bit_serializer_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    // Helpers work on a fixed wide vector; callers zero-extend and truncate.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] lsb_isolate(input logic [MAX_W-1:0] x);
        return x & (~x + MAX_W'(1));
    endfunction

endpackage

// File: rtl/set_bit_serializer_onehot_to_idx.sv
// Combinational one-hot to binary index encoder; all-zero input gives index 0.
module onehot_to_idx #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // OR-reduction form: exact for a one-hot input, no priority chain.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/set_bit_serializer.sv
// Expands a word into one output beat per set bit, LSB first, with full throughput.
// Define SET_BIT_SERIALIZER_COUNT_EN to add bit_cnt_o (popcount of the current word).
module set_bit_serializer
    import set_bit_serializer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] bit_onehot_o,
    output logic [IDX_W-1:0] bit_idx_o,
    output logic             bit_last_o,
    output logic             bit_val_o,
    input  logic             bit_ready_i
`ifdef SET_BIT_SERIALIZER_COUNT_EN
    ,
    output logic [IDX_W:0]   bit_cnt_o
`endif
);

    state_t           state;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] onehot_next;
    logic [WIDTH-1:0] rem_next;
    logic [IDX_W-1:0] idx_next;
    logic             accept;
    logic             pop;
    logic             advance;

    assign pop          = bit_val_o & bit_ready_i;
    assign data_ready_o = !srst_i & ((state == IDLE) | (pop & bit_last_o));
    assign accept       = data_val_i & data_ready_o;
    // A new word and the next bit of the current word load the same way.
    assign advance      = accept | (pop & !bit_last_o);

    always_comb begin
        src         = accept ? data_i : remaining;
        onehot_next = WIDTH'(lsb_isolate(MAX_W'(src)));
        rem_next    = src & ~onehot_next;
    end

    onehot_to_idx #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_idx (
        .onehot (onehot_next),
        .idx    (idx_next)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state        <= IDLE;
            remaining    <= '0;
            bit_val_o    <= 1'b0;
            bit_onehot_o <= '0;
            bit_idx_o    <= '0;
            bit_last_o   <= 1'b0;
        end else if (advance) begin
            state        <= BUSY;
            remaining    <= rem_next;
            bit_val_o    <= 1'b1;
            bit_onehot_o <= onehot_next;
            bit_idx_o    <= idx_next;
            bit_last_o   <= (rem_next == '0);
        end else if (pop) begin
            state        <= IDLE;
            remaining    <= '0;
            bit_val_o    <= 1'b0;
            bit_onehot_o <= '0;
            bit_idx_o    <= '0;
            bit_last_o   <= 1'b0;
        end
    end

`ifdef SET_BIT_SERIALIZER_COUNT_EN
    logic [IDX_W:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < WIDTH; i++) cnt_next = cnt_next + (IDX_W+1)'(data_i[i]);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i)      bit_cnt_o <= '0;
        else if (accept) bit_cnt_o <= cnt_next;
        else if (pop && bit_last_o) bit_cnt_o <= '0;
    end
`endif

endmodule

// File: tb/tb_set_bit_serializer.sv
// Self-checking bench: queue-of-beats reference model, directed plan then random traffic.
module tb_set_bit_serializer;

    localparam int W  = 16;
    localparam int IW = 4;

    typedef struct {
        logic [W-1:0]  oh;
        logic [IW-1:0] idx;
        logic          last;
        logic [IW:0]   cnt;
    } beat_t;

    logic          clk = 1'b0;
    logic          srst, dval, rdy;
    logic [W-1:0]  data;
    logic          data_ready, bit_last, bit_val;
    logic [W-1:0]  bit_onehot;
    logic [IW-1:0] bit_idx;
`ifdef SET_BIT_SERIALIZER_COUNT_EN
    logic [IW:0]   bit_cnt;
`endif

    beat_t q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    set_bit_serializer #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .data_i       (data),
        .data_val_i   (dval),
        .data_ready_o (data_ready),
        .bit_onehot_o (bit_onehot),
        .bit_idx_o    (bit_idx),
        .bit_last_o   (bit_last),
        .bit_val_o    (bit_val),
        .bit_ready_i  (rdy)
`ifdef SET_BIT_SERIALIZER_COUNT_EN
        ,
        .bit_cnt_o    (bit_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a word becomes the list of its set bits in ascending order.
    task automatic push_word(input logic [W-1:0] d);
        beat_t b;
        int    c = 0;
        for (int i = 0; i < W; i++) if (d[i]) c++;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                b.oh     = '0;
                b.oh[i]  = 1'b1;
                b.idx    = IW'(i);
                b.last   = 1'b0;
                b.cnt    = (IW+1)'(c);
                q.push_back(b);
            end
        end
        if (c == 0) begin
            b.oh = '0; b.idx = '0; b.last = 1'b0; b.cnt = '0;
            q.push_back(b);
        end
        q[q.size()-1].last = 1'b1;
    endtask

    // One clock: drive inputs, check outputs against model, advance model at the edge.
    task automatic cyc(input logic rst, input logic v, input logic [W-1:0] d, input logic r);
        beat_t e;
        logic  e_val, e_ready, do_pop, do_acc;
        srst = rst; dval = v; data = d; rdy = r;
        #1;
        e_val   = (q.size() > 0);
        e_ready = !rst && (q.size() == 0 || (r && q.size() == 1));
        if (e_val) e = q[0];
        else begin e.oh = '0; e.idx = '0; e.last = 1'b0; e.cnt = '0; end
        chk("bit_val",    32'(bit_val),    32'(e_val));
        chk("onehot",     32'(bit_onehot), 32'(e.oh));
        chk("idx",        32'(bit_idx),    32'(e.idx));
        chk("last",       32'(bit_last),   32'(e.last));
        chk("data_ready", 32'(data_ready), 32'(e_ready));
`ifdef SET_BIT_SERIALIZER_COUNT_EN
        chk("bit_cnt",    32'(bit_cnt),    32'(e.cnt));
`endif
        do_pop = e_val && r;
        do_acc = v && e_ready;
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_acc) push_word(d);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] d;
        srst = 1'b1; dval = 1'b0; data = '0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc(1, 0, '0, 0);                       // reset state

        cyc(0, 1, 16'h8421, 1);                 // four beats, no gaps
        repeat (4) cyc(0, 0, W'($urandom), 1);
        cyc(0, 0, '0, 1);

        cyc(0, 1, 16'h0000, 1);                 // empty word: single last beat
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);

        cyc(0, 1, 16'h0003, 1);                 // back-to-back without bubble
        cyc(0, 0, '0, 1);
        cyc(0, 1, 16'h8000, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);

        cyc(0, 1, 16'h00F0, 1);                 // stalls with data_val held high
        for (int i = 0; i < 8; i++) cyc(0, i < 6, W'($urandom), i[0]);
        cyc(0, 0, '0, 1);

        cyc(0, 1, 16'hFFFF, 1);                 // reset mid-word
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        cyc(1, 0, '0, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 1, 16'h0100, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);

        cyc(0, 1, 16'hFFFF, 1);                 // all ones: 16 beats
        repeat (17) cyc(0, 0, '0, 1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0:       d = W'($urandom);
                1:       d = W'($urandom & $urandom & $urandom);
                2:       d = ($urandom % 2) ? '0 : '1;
                default: d = W'(1) << ($urandom % W);
            endcase
            cyc(($urandom % 64) == 0, ($urandom % 3) != 0, d, ($urandom % 4) != 0);
        end
        repeat (20) cyc(0, 0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/set_bit_serializer.md
Name: set_bit_serializer

Overview:
- Walks an input word and emits every set bit, one per output beat, LSB first, as a one-hot mask plus its binary index.
- Sits downstream of the priority encoding logic: where the encoder collapses a word to its extreme set bits, this block expands a word back into its full list of set bits.
- Valid/ready on both sides, registered outputs, full throughput (one bit per cycle, no bubble between words).

Parameters:
- WIDTH, 16, data word width; power of two, >= 2.
- IDX_W, $clog2(WIDTH), index width; derived, do not override.

Ports:
- clk_i  input  1  clock.
- srst_i  input  1  synchronous active-high reset.
- data_i  input  WIDTH  word to serialize.
- data_val_i  input  1  data_i valid.
- data_ready_o  output  1  block can accept data_i this cycle.
- bit_onehot_o  output  WIDTH  one-hot mask of current set bit; all zero for an empty word.
- bit_idx_o  output  IDX_W  index of current set bit; 0 for an empty word.
- bit_last_o  output  1  current beat is the final beat of the word.
- bit_val_o  output  1  output beat valid.
- bit_ready_i  input  1  downstream accepts beat.

Behaviour:
- One clock (clk_i); reset srst_i is synchronous, active-high.
- Reset values:
  - State goes to IDLE.
  - bit_val_o=0, bit_onehot_o=0, bit_idx_o=0, bit_last_o=0.
  - Internal remaining-mask register = 0.
  - data_ready_o=0 while srst_i=1.
- States:
  - IDLE: no beat pending.
  - BUSY: beat on outputs, possibly more bits remaining.
- Handshakes:
  - Input handshake (accept) = data_val_i & data_ready_o.
  - Output handshake (pop) = bit_val_o & bit_ready_i.
- data_ready_o (combinational) = !srst_i & ( state==IDLE | (pop & bit_last_o) ).
- Accept:
  - The next cycle presents the first beat: bit_val_o=1, bit_onehot_o = data_i & (~data_i+1) truncated to WIDTH, bit_idx_o = its index.
  - remaining is loaded with data_i with that lowest bit cleared.
  - bit_last_o = (remaining after clear == 0).
  - State goes to BUSY.
  - Latency from accept to first beat: 1 cycle.
- Empty word (data_i==0): exactly one beat with bit_onehot_o=0, bit_idx_o=0, bit_last_o=1.
- Pop without last: the next cycle presents the lowest bit of remaining, remaining &= remaining-1, and bit_last_o is recomputed. One beat per cycle under continuous bit_ready_i.
- Pop with last and simultaneous accept: the next cycle presents the first beat of the new word (no bubble).
- Pop with last and no accept: bit_val_o drops to 0 next cycle, outputs go to zero, state goes to IDLE.
- Stall (bit_val_o & !bit_ready_i): all outputs and remaining hold stable. data_val_i is ignored because data_ready_o=0.
- Word with a single set bit: one beat with bit_last_o=1.
- Word with all bits set: WIDTH beats, indices 0..WIDTH-1, last on index WIDTH-1.
- Reset mid-word: the word is discarded. The cycle after srst_i deasserts shows bit_val_o=0 and data_ready_o=1.
- data_i is sampled only on accept; changes at other times have no effect.

Optional Feature:
- Macro SET_BIT_SERIALIZER_COUNT_EN.
- When defined:
  - Adds output bit_cnt_o, width IDX_W+1.
  - On accept it registers popcount(data_i) and holds it for every beat of that word.
  - Value is 0 for an empty word and WIDTH for all-ones.
  - Reset value is 0.
- When undefined: the port and the popcount logic are absent; all other behaviour is identical.

Decomposition:
- Package set_bit_serializer_pkg:
  - state_t enum {IDLE, BUSY}.
  - Function lsb_isolate(x) returning x & -x.
- Sub-module onehot_to_idx: combinational one-hot to binary index, parameter WIDTH, used for bit_idx_o. Reusable by other blocks in the same design that consume one-hot masks.

Test Plan (WIDTH=16):
- Reset, then data_i=16'h8421 with data_val_i=1 and bit_ready_i=1 always -> 4 beats on consecutive cycles:
  - onehot 0001/0020/0400/8000, idx 0/5/10/15.
  - last only on the 4th beat.
  - First beat 1 cycle after accept.
- data_i=16'h0000 -> single beat, onehot 0, idx 0, last=1; data_ready_o high in the same cycle as that pop.
- Back-to-back words 16'h0003 then 16'h8000 -> beats idx 1? no: idx 0, idx 1(last), idx 15(last) on 3 consecutive cycles with no bubble.
- data_i=16'h00F0 with bit_ready_i toggling 0/1 -> outputs hold during stalls; idx 4,5,6,7 in order; data_ready_o=0 throughout.
- srst_i=1 after the 2nd beat of 16'hFFFF -> next cycle bit_val_o=0, all outputs 0; a new word 16'h0100 then yields one beat, idx 8, last=1.
- SET_BIT_SERIALIZER_COUNT_EN build with 16'hFFFF -> 16 beats idx 0..15, bit_cnt_o=16 on every beat; 16'h0000 -> bit_cnt_o=0.
